frl_ckpt: RTL
=============

Name: frl_ckpt

Overview:
Next-generation free register list for the rename stage, parametrised in physical register count, allocate width and free width. It adds head-pointer checkpoints so that branch-mispredict recovery returns speculatively allocated registers to the list in one cycle. It has an all-or-nothing allocation handshake, an exact free count, and a sticky error flag. Rename allocates from it; ROB commit returns registers to it.

Parameters:
NUM_PHYS_REGS, reg_pkg::NUM_PHYS_REGS (64): physical register count; must be a power of 2.
NUM_ARCH_REGS, reg_pkg::NUM_ARCH_REGS (32): registers mapped architecturally at reset, so never initially free.
ALLOC_WIDTH, uop_pkg::INSTR_Q_WIDTH (4): allocate lanes per cycle.
FREE_WIDTH, uop_pkg::INSTR_Q_WIDTH (4): free lanes per cycle.
NUM_CKPT, 4: number of checkpoint slots.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  synchronous, active-low reset.
alloc_req_in  in  ALLOC_WIDTH  lane request mask; must be contiguous from lane 0.
alloc_grant_out  out  1  all requested lanes granted this cycle.
alloc_regs_out  out  ALLOC_WIDTH x PREG_W  lane i = entry at head+i; always driven.
free_valid_in  in  FREE_WIDTH  per-lane free strobe; any pattern allowed.
free_regs_in  in  FREE_WIDTH x PREG_W  registers being freed.
ckpt_take_in  in  1  save the post-update head into slot ckpt_id_in.
ckpt_id_in  in  CKPT_W  checkpoint slot index.
restore_in  in  1  restore head from slot restore_id_in.
restore_id_in  in  CKPT_W  slot to restore.
free_count_out  out  PREG_W+1  registered number of free entries.
err_out  out  1  sticky error: overflow, or restore of an invalid slot.

Behaviour:
- Width: PREG_W = $clog2(NUM_PHYS_REGS).
- Storage: circular FIFO of NUM_PHYS_REGS entries, each PREG_W bits.
- Pointers: head_r and tail_r are PREG_W+1 bits (wrap bit); index = low PREG_W bits.
- count = tail_r - head_r, computed modulo 2^(PREG_W+1).
- Reset (rst_n low at posedge):
  - entry[i] = NUM_ARCH_REGS+i for i < NUM_PHYS_REGS-NUM_ARCH_REGS; remaining entries = 0.
  - head_r = 0; tail_r = NUM_PHYS_REGS-NUM_ARCH_REGS.
  - All checkpoint slot valid bits cleared; err_out = 0; free_count_out = NUM_PHYS_REGS-NUM_ARCH_REGS.
  - Reset overrides every other input in that cycle.
- Allocation (combinational grant, zero latency):
  - req_n = popcount(alloc_req_in).
  - alloc_grant_out = (req_n != 0) && (count >= req_n) && !restore_in.
  - On grant, head advances by req_n at the posedge. No grant means no head change and no partial grant.
  - alloc_regs_out reflects current head_r and does not see same-cycle frees.
- Free:
  - Valid lanes are compacted in lane order and written at tail, tail+1, ...
  - tail advances by popcount(free_valid_in).
  - Frees apply in every cycle, including restore cycles.
  - Freed registers become allocatable the next cycle.
  - If count - granted + freed > NUM_PHYS_REGS: set err_out; the excess writes are still performed (data undefined).
- Checkpoint:
  - ckpt_take_in writes head_n (head after this cycle's grant) into slot ckpt_id_in and sets its valid bit.
  - Overwriting a valid slot is allowed.
- Restore:
  - restore_in sets head_n = slot[restore_id_in].head and suppresses grant.
  - The slot's valid bit is cleared.
  - Restoring an invalid slot sets err_out and leaves head unchanged.
  - Restore plus checkpoint in the same cycle: the checkpoint stores the restored head.
  - Restore plus checkpoint on the same id: the checkpoint wins, valid = 1.
- Wrap-around: all pointer arithmetic is modulo 2^(PREG_W+1). Full = count == NUM_PHYS_REGS; empty = count == 0.
- free_count_out = registered count_n, i.e. one cycle after the event.

Decomposition:
- reg_pkg: NUM_PHYS_REGS, NUM_ARCH_REGS, preg_t typedef (PREG_W bits), frl_ptr_t typedef (PREG_W+1 bits).
- rob_pkg: NUM_CKPT and ckpt_id_t, shared with the ROB and branch unit.
- One sub-module, frl_compact: a combinational FREE_WIDTH-lane compactor that outputs the packed register list and its popcount. It is reused by the ROB commit path.

Test Plan:
- Reset with 64/32/4/4 -> free_count_out = 32, alloc_regs_out = {32,33,34,35}, err_out = 0.
- alloc_req_in = 4'b0111 for 10 cycles -> 10 grants, head = 30. Then 4'b1111 with count 2 -> no grant, head unchanged, regs_out = {62,63,x,x}.
- Take checkpoint slot 1 at head = 8, then 3 grants of 4 lanes, then restore slot 1 -> head = 8, grant low in the restore cycle, free_count_out back to 24 the next cycle.
- free_valid_in = 4'b1010 with regs {5,9} while count = 32 -> entries 32 and 33 (mod 64) hold 5 and 9, count = 34 a cycle later; both allocated after wrap.
- Same cycle: grant 4 lanes, free 2, take checkpoint slot 0 -> slot 0 holds head+4; count changes by -2.
- Restore an invalid slot 3 -> err_out = 1 and sticky, head unchanged. rst_n low mid-operation -> full reset state the next cycle.

Source files
------------

// File: rtl/frl_ckpt_pkg.sv
// frl_ckpt_pkg: free-list helpers
package frl_ckpt_pkg;
  function automatic int init_entry(int i, int nphys, int narch);
    return (i < nphys - narch) ? narch + i : 0;
  endfunction
endpackage

// File: rtl/reg_pkg.sv
// reg_pkg: physical register file sizing shared by rename and the free list
package reg_pkg;
  localparam int NUM_PHYS_REGS = 64;
  localparam int NUM_ARCH_REGS = 32;
  localparam int PREG_W = $clog2(NUM_PHYS_REGS);
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0] frl_ptr_t;
endpackage

// File: rtl/rob_pkg.sv
// rob_pkg: checkpoint sizing shared by the ROB, branch unit and free list
package rob_pkg;
  localparam int NUM_CKPT = 4;
  typedef logic [$clog2(NUM_CKPT)-1:0] ckpt_id_t;
endpackage

// File: rtl/uop_pkg.sv
// uop_pkg: front-end uop queue sizing
package uop_pkg;
  localparam int INSTR_Q_WIDTH = 4;
endpackage

// File: rtl/frl_compact.sv
// frl_compact: packs valid lanes into lane order and counts them
module frl_compact #(
  parameter int WIDTH = 4,
  parameter int DATA_W = 6,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]             valid_in,
  input  logic [WIDTH-1:0][DATA_W-1:0] data_in,
  output logic [WIDTH-1:0][DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]             count_out
);
  always_comb begin
    data_out = '0;
    count_out = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int o = 0; o < WIDTH; o++)
        if (valid_in[j] && count_out == CNT_W'(o)) data_out[o] = data_in[j];
      count_out = count_out + CNT_W'(valid_in[j]);
    end
  end
endmodule

// File: rtl/frl_ckpt.sv
// frl_ckpt: circular free register list with head checkpoints for one-cycle mispredict recovery
module frl_ckpt
  import frl_ckpt_pkg::*;
#(
  parameter int NUM_PHYS_REGS = reg_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = reg_pkg::NUM_ARCH_REGS,
  parameter int ALLOC_WIDTH = uop_pkg::INSTR_Q_WIDTH,
  parameter int FREE_WIDTH = uop_pkg::INSTR_Q_WIDTH,
  parameter int NUM_CKPT = rob_pkg::NUM_CKPT,
  localparam int PREG_W = $clog2(NUM_PHYS_REGS),
  localparam int CKPT_W = $clog2(NUM_CKPT)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [ALLOC_WIDTH-1:0]              alloc_req_in,
  output logic                                alloc_grant_out,
  output logic [ALLOC_WIDTH-1:0][PREG_W-1:0]  alloc_regs_out,
  input  logic [FREE_WIDTH-1:0]               free_valid_in,
  input  logic [FREE_WIDTH-1:0][PREG_W-1:0]   free_regs_in,
  input  logic                                ckpt_take_in,
  input  logic [CKPT_W-1:0]                   ckpt_id_in,
  input  logic                                restore_in,
  input  logic [CKPT_W-1:0]                   restore_id_in,
  output logic [PREG_W:0]                     free_count_out,
  output logic                                err_out
);
  localparam int PTR_W = PREG_W + 1;
  localparam int AC_W = $clog2(ALLOC_WIDTH + 1);
  localparam int FC_W = $clog2(FREE_WIDTH + 1);
  localparam int EW = PTR_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PREG_W-1:0] idx_t;
  ptr_t head_q, head_d, tail_q, tail_d, count, free_count_q, free_count_d;
  logic [NUM_PHYS_REGS-1:0][PREG_W-1:0] mem_q, mem_d;
  ptr_t [NUM_CKPT-1:0] ckpt_head_q, ckpt_head_d;
  logic [NUM_CKPT-1:0] ckpt_valid_q, ckpt_valid_d;
  logic err_q, err_d;
  logic [AC_W-1:0] req_n;
  logic [FREE_WIDTH-1:0][PREG_W-1:0] packed_regs;
  logic [FC_W-1:0] free_n;
  logic [EW-1:0] occ_n;
  logic restore_ok;

  frl_compact #(.WIDTH(FREE_WIDTH), .DATA_W(PREG_W)) u_compact (
    .valid_in (free_valid_in),
    .data_in  (free_regs_in),
    .data_out (packed_regs),
    .count_out(free_n)
  );

  always_comb begin
    req_n = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) req_n = req_n + AC_W'(alloc_req_in[i]);
  end

  assign count = tail_q - head_q;
  assign alloc_grant_out = (req_n != '0) && (count >= PTR_W'(req_n)) && !restore_in;
  assign restore_ok = ckpt_valid_q[restore_id_in];
  // widened so an overfilled list is detectable rather than aliasing to a small count
  assign occ_n = EW'(count) - (alloc_grant_out ? EW'(req_n) : '0) + EW'(free_n);
  assign free_count_out = free_count_q;
  assign err_out = err_q;

  for (genvar g = 0; g < ALLOC_WIDTH; g++)
    assign alloc_regs_out[g] = mem_q[idx_t'(head_q + PTR_W'(g))];

  always_comb begin
    head_d = restore_in ? (restore_ok ? ckpt_head_q[restore_id_in] : head_q)
                        : (alloc_grant_out ? head_q + PTR_W'(req_n) : head_q);
    tail_d = tail_q + PTR_W'(free_n);
    free_count_d = tail_d - head_d;
    err_d = err_q | (occ_n > EW'(NUM_PHYS_REGS)) | (restore_in & !restore_ok);
    mem_d = mem_q;
    for (int i = 0; i < FREE_WIDTH; i++)
      if (FC_W'(i) < free_n) mem_d[idx_t'(tail_q + PTR_W'(i))] = packed_regs[i];
    ckpt_head_d = ckpt_head_q;
    ckpt_valid_d = ckpt_valid_q;
    if (restore_in) ckpt_valid_d[restore_id_in] = 1'b0;
    // a same-slot take after the restore clear leaves the slot valid
    if (ckpt_take_in) begin
      ckpt_head_d[ckpt_id_in] = head_d;
      ckpt_valid_d[ckpt_id_in] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS_REGS; i++)
        mem_q[i] <= PREG_W'(init_entry(i, NUM_PHYS_REGS, NUM_ARCH_REGS));
      head_q <= '0;
      tail_q <= PTR_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      free_count_q <= PTR_W'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      ckpt_head_q <= '0;
      ckpt_valid_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      free_count_q <= free_count_d;
      ckpt_head_q <= ckpt_head_d;
      ckpt_valid_q <= ckpt_valid_d;
      err_q <= err_d;
    end
  end
endmodule
